// File: rtl/uart_frame_pkg.sv
// Shared constants, FSM state and error encodings for the UART frame parser.
package uart_frame_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN    = 3'd1,
    ST_PAY_LO = 3'd2,
    ST_PAY_HI = 3'd3,
    ST_CHK    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CHK     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  function automatic logic [7:0] reply_byte(input logic ok);
    return ok ? ACK_BYTE : NAK_BYTE;
  endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte idle counter: cleared by each byte, held at zero while disabled,
// o_expired is high in the cycle the idle count reaches TIMEOUT_CYCLES.
module uart_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] r_count;
  logic         w_hit;

  // A byte arriving in the would-be expiry cycle suppresses the hit.
  assign w_hit     = i_en && !i_clr && (r_count == W'(TIMEOUT_CYCLES - 1));
  assign o_expired = w_hit;

  // Idle cycle counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (!i_en || i_clr || w_hit) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SOF/LEN/payload/CHK frames from the UART byte stream, streams samples
// and queues a one-byte ACK/NAK reply for the transmitter.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int MAX_SAMPLES    = 64,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_valid,
  input  logic        i_tx_ready,
  output logic        o_send,
  output logic [7:0]  o_tx_byte,
  output logic [15:0] o_sample_data,
  output logic        o_sample_valid,
  output logic        o_frame_done,
  output logic        o_frame_ok,
  output logic [1:0]  o_err_code,
  output logic        o_reply_overrun
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [7:0]  r_samples_left;
  logic [7:0]  r_sum;
  logic [7:0]  r_lo;
  logic        r_slot_valid;
  logic [7:0]  r_slot_byte;

  logic        r_send;
  logic [7:0]  r_tx_byte;
  logic [15:0] r_sample_data;
  logic        r_sample_valid;
  logic        r_frame_done;
  logic        r_frame_ok;
  err_e        r_err_code;
  logic        r_reply_overrun;

  logic        w_expired;
  logic        w_len_bad;
  logic        w_issue;
  logic        w_sample_fire;
  logic        w_frame_end;
  logic        w_frame_ok;
  err_e        w_err;

  uart_byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_en      (r_state != ST_IDLE),
    .i_clr     (i_rx_valid),
    .o_expired (w_expired)
  );

  assign w_len_bad = (i_rx_byte == 8'd0) || (int'(i_rx_byte) > MAX_SAMPLES);
  assign w_issue   = r_slot_valid && i_tx_ready && !r_send;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; 0xA5 inside a frame is ordinary payload
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_rx_valid && (i_rx_byte == SOF_BYTE)) w_state_nxt = ST_LEN;
        else                                       w_state_nxt = ST_IDLE;
      end
      ST_LEN: begin
        if (i_rx_valid)     w_state_nxt = w_len_bad ? ST_IDLE : ST_PAY_LO;
        else if (w_expired) w_state_nxt = ST_IDLE;
        else                w_state_nxt = ST_LEN;
      end
      ST_PAY_LO: begin
        if (i_rx_valid)     w_state_nxt = ST_PAY_HI;
        else if (w_expired) w_state_nxt = ST_IDLE;
        else                w_state_nxt = ST_PAY_LO;
      end
      ST_PAY_HI: begin
        if (i_rx_valid)     w_state_nxt = (r_samples_left == 8'd1) ? ST_CHK : ST_PAY_LO;
        else if (w_expired) w_state_nxt = ST_IDLE;
        else                w_state_nxt = ST_PAY_HI;
      end
      ST_CHK: begin
        if (i_rx_valid || w_expired) w_state_nxt = ST_IDLE;
        else                         w_state_nxt = ST_CHK;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output decode: sample strobe and frame-end classification
  always_comb begin
    w_sample_fire = (r_state == ST_PAY_HI) && i_rx_valid;
    w_frame_end   = 1'b0;
    w_frame_ok    = 1'b0;
    w_err         = ERR_NONE;
    case (r_state)
      ST_LEN: begin
        if (i_rx_valid && w_len_bad) begin
          w_frame_end = 1'b1;
          w_err       = ERR_LEN;
        end else if (w_expired) begin
          w_frame_end = 1'b1;
          w_err       = ERR_TIMEOUT;
        end else begin
          w_frame_end = 1'b0;
        end
      end
      ST_PAY_LO, ST_PAY_HI: begin
        if (w_expired) begin
          w_frame_end = 1'b1;
          w_err       = ERR_TIMEOUT;
        end else begin
          w_frame_end = 1'b0;
        end
      end
      ST_CHK: begin
        if (i_rx_valid) begin
          w_frame_end = 1'b1;
          w_frame_ok  = (r_sum == i_rx_byte);
          w_err       = (r_sum == i_rx_byte) ? ERR_NONE : ERR_CHK;
        end else if (w_expired) begin
          w_frame_end = 1'b1;
          w_err       = ERR_TIMEOUT;
        end else begin
          w_frame_end = 1'b0;
        end
      end
      default: w_frame_end = 1'b0;
    endcase
  end

  // Payload datapath: sample counter, running checksum, low-byte holding
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_samples_left <= 8'd0;
      r_sum          <= 8'd0;
      r_lo           <= 8'd0;
      r_sample_valid <= 1'b0;
      r_sample_data  <= 16'h0000;
    end else begin
      r_sample_valid <= w_sample_fire;
      if (w_sample_fire) r_sample_data <= {i_rx_byte, r_lo};
      if ((r_state == ST_PAY_LO) && i_rx_valid) r_lo <= i_rx_byte;
      if ((r_state == ST_LEN) && i_rx_valid) begin
        r_samples_left <= i_rx_byte;
        r_sum          <= i_rx_byte;
      end else if (((r_state == ST_PAY_LO) || (r_state == ST_PAY_HI)) && i_rx_valid) begin
        r_sum <= r_sum + i_rx_byte;
        if (w_sample_fire) r_samples_left <= r_samples_left - 8'd1;
      end
    end
  end

  // Frame status and the single-entry reply slot; a new reply outranks an unsent one
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frame_done    <= 1'b0;
      r_frame_ok      <= 1'b0;
      r_err_code      <= ERR_NONE;
      r_slot_valid    <= 1'b0;
      r_slot_byte     <= 8'h00;
      r_send          <= 1'b0;
      r_tx_byte       <= 8'h00;
      r_reply_overrun <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      r_send       <= w_issue;
      if (w_issue) r_tx_byte <= r_slot_byte;
      if (w_frame_end) begin
        r_frame_ok      <= w_frame_ok;
        r_err_code      <= w_err;
        r_slot_valid    <= 1'b1;
        r_slot_byte     <= reply_byte(w_frame_ok);
        r_reply_overrun <= r_slot_valid && !w_issue;
      end else begin
        r_reply_overrun <= 1'b0;
        if (w_issue) r_slot_valid <= 1'b0;
      end
    end
  end

  assign o_send          = r_send;
  assign o_tx_byte       = r_tx_byte;
  assign o_sample_data   = r_sample_data;
  assign o_sample_valid  = r_sample_valid;
  assign o_frame_done    = r_frame_done;
  assign o_frame_ok      = r_frame_ok;
  assign o_err_code      = r_err_code;
  assign o_reply_overrun = r_reply_overrun;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench: byte-stream reference model compared every cycle, plus
// directed frames with hand-computed expectations and a randomized phase.
module tb_uart_frame_parser;

  localparam int TB_MAX = 8;
  localparam int TB_T   = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b1;
  logic        o_send;
  logic [7:0]  o_tx_byte;
  logic [15:0] o_sample_data;
  logic        o_sample_valid;
  logic        o_frame_done;
  logic        o_frame_ok;
  logic [1:0]  o_err_code;
  logic        o_reply_overrun;

  uart_frame_parser #(.MAX_SAMPLES(TB_MAX), .TIMEOUT_CYCLES(TB_T)) dut (
    .i_clk(clk), .i_reset(reset), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
    .i_tx_ready(tx_ready), .o_send(o_send), .o_tx_byte(o_tx_byte),
    .o_sample_data(o_sample_data), .o_sample_valid(o_sample_valid),
    .o_frame_done(o_frame_done), .o_frame_ok(o_frame_ok),
    .o_err_code(o_err_code), .o_reply_overrun(o_reply_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  bit rnd_tx   = 1'b0;

  // Reference model state: the frame is kept as a byte list, not as FSM states
  bit          m_in = 1'b0;
  logic [7:0]  m_buf[$];
  int          m_last = 0;
  int          cyc = 0;
  bit          m_slot_p = 1'b0;
  logic [7:0]  m_slot_b = 8'h00;
  logic        e_send = 1'b0, e_sv = 1'b0, e_fd = 1'b0, e_ok = 1'b0, e_ov = 1'b0;
  logic [7:0]  e_tx = 8'h00;
  logic [15:0] e_sd = 16'h0000;
  logic [1:0]  e_err = 2'd0;

  // Observed DUT activity for the directed literal checks
  logic [15:0] q_samp[$];
  logic [2:0]  q_fr[$];
  logic [7:0]  q_tx[$];
  int          n_ovr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step();
    logic issue, fend, fok;
    logic [1:0] ferr;
    int n, L, s;
    if (reset) begin
      m_in = 1'b0; m_buf.delete(); m_slot_p = 1'b0; m_slot_b = 8'h00;
      e_send = 1'b0; e_tx = 8'h00; e_sv = 1'b0; e_sd = 16'h0000;
      e_fd = 1'b0; e_ok = 1'b0; e_err = 2'd0; e_ov = 1'b0;
      return;
    end
    e_sv = 1'b0; e_fd = 1'b0; e_ov = 1'b0;
    issue = m_slot_p && tx_ready && !e_send;
    e_send = issue;
    if (issue) e_tx = m_slot_b;
    fend = 1'b0; fok = 1'b0; ferr = 2'd0;
    if (rx_valid) begin
      m_last = cyc;
      if (!m_in) begin
        if (rx_byte == 8'hA5) begin m_in = 1'b1; m_buf.delete(); end
      end else begin
        m_buf.push_back(rx_byte);
        n = m_buf.size();
        L = int'(m_buf[0]);
        if (n == 1) begin
          if (L == 0 || L > TB_MAX) begin fend = 1'b1; ferr = 2'd1; end
        end else if (n <= 2 * L + 1) begin
          if (n % 2 == 1) begin e_sv = 1'b1; e_sd = {m_buf[n-1], m_buf[n-2]}; end
        end else begin
          s = 0;
          for (int i = 0; i < n - 1; i++) s += int'(m_buf[i]);
          fend = 1'b1;
          fok  = ((s % 256) == int'(rx_byte));
          ferr = fok ? 2'd0 : 2'd2;
        end
      end
    end else if (m_in && (cyc - m_last == TB_T)) begin
      fend = 1'b1; ferr = 2'd3;
    end
    if (fend) begin
      m_in = 1'b0; e_fd = 1'b1; e_ok = fok; e_err = ferr;
      e_ov = m_slot_p && !issue;
      m_slot_p = 1'b1;
      m_slot_b = fok ? 8'h06 : 8'h15;
    end else if (issue) begin
      m_slot_p = 1'b0;
    end
  endtask

  // Compare, log, then advance the model with this cycle's inputs
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("send", o_send, e_send);
        if (e_send) check("tx_byte", o_tx_byte, e_tx);
        check("sample_valid", o_sample_valid, e_sv);
        if (e_sv) check("sample_data", o_sample_data, e_sd);
        check("frame_done", o_frame_done, e_fd);
        if (e_fd) check("frame_ok", o_frame_ok, e_ok);
        check("err_code", o_err_code, e_err);
        check("reply_overrun", o_reply_overrun, e_ov);
      end
      if (o_sample_valid === 1'b1) q_samp.push_back(o_sample_data);
      if (o_frame_done === 1'b1) q_fr.push_back({o_frame_ok, o_err_code});
      if (o_send === 1'b1) q_tx.push_back(o_tx_byte);
      if (o_reply_overrun === 1'b1) n_ovr++;
      model_step();
      cyc++;
    end
  end

  task automatic put(input logic [7:0] b);
    if (rnd_tx) tx_ready = ($urandom_range(0, 3) != 0);
    rx_byte = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_byte = 8'($urandom);
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic put_seq(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) put(v[8*i +: 8]);
  endtask

  task automatic clear_logs();
    q_samp.delete(); q_fr.delete(); q_tx.delete(); n_ovr = 0;
  endtask

  logic [7:0] fb[$];
  logic [7:0] pb;
  int         fl, fs, fr, gap;

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    check("rst_send", o_send, 32'h0);
    check("rst_sample_valid", o_sample_valid, 32'h0);
    check("rst_frame_done", o_frame_done, 32'h0);
    check("rst_err_code", o_err_code, 32'h0);
    check("rst_sample_data", o_sample_data, 32'h0);

    // good frame
    clear_logs(); put_seq(64'hA5023412785616, 7); idle(4);
    check("t1_nsamp", q_samp.size(), 32'd2);
    check("t1_samp0", q_samp[0], 32'h1234);
    check("t1_samp1", q_samp[1], 32'h5678);
    check("t1_frame", q_fr[0], 32'h4);
    check("t1_reply", q_tx[0], 32'h06);

    // bad checksum: samples still stream
    clear_logs(); put_seq(64'hA5023412785617, 7); idle(4);
    check("t2_nsamp", q_samp.size(), 32'd2);
    check("t2_frame", q_fr[0], 32'h2);
    check("t2_reply", q_tx[0], 32'h15);

    // leading junk, then bad LEN, then recovery
    clear_logs(); put_seq(64'h00FFA501CDAB79, 7); idle(4);
    check("t3_samp", q_samp[0], 32'hABCD);
    check("t3_reply", q_tx[0], 32'h06);
    clear_logs(); put_seq(64'hA500, 2); idle(4);
    check("t3_badlen", q_fr[0], 32'h1);
    check("t3_badlen_reply", q_tx[0], 32'h15);
    clear_logs(); put_seq(64'hA501CDAB79, 5); idle(4);
    check("t3_recover", q_fr[0], 32'h4);

    // timeout, then byte landing on the exact expiry cycle
    clear_logs(); put_seq(64'hA50134, 3); idle(TB_T + 3);
    check("t4_timeout", q_fr[0], 32'h3);
    check("t4_timeout_reply", q_tx[0], 32'h15);
    clear_logs(); put_seq(64'hA50134, 3); idle(TB_T - 1); put(8'h12); put(8'h47); idle(4);
    check("t4_edge_nframe", q_fr.size(), 32'd1);
    check("t4_edge_frame", q_fr[0], 32'h4);

    // blocked transmitter and reply overrun
    clear_logs(); tx_ready = 1'b0; put_seq(64'hA5023412785616, 7); idle(1000);
    check("t5_blocked", q_tx.size(), 32'd0);
    tx_ready = 1'b1; idle(3);
    check("t5_nsend", q_tx.size(), 32'd1);
    check("t5_reply", q_tx[0], 32'h06);
    clear_logs(); tx_ready = 1'b0;
    put_seq(64'hA501CDAB79, 5); idle(5); put_seq(64'hA501CDAB7A, 5); idle(5);
    tx_ready = 1'b1; idle(5);
    check("t5_overrun", n_ovr, 32'd1);
    check("t5_ov_nsend", q_tx.size(), 32'd1);
    check("t5_ov_reply", q_tx[0], 32'h15);

    // reset mid-frame and with a reply pending
    clear_logs(); put_seq(64'hA50234, 3); reset = 1'b1; idle(2); reset = 1'b0; idle(3);
    tx_ready = 1'b0; put_seq(64'hA501CDAB79, 5); idle(3);
    reset = 1'b1; idle(1); tx_ready = 1'b1; idle(1); reset = 1'b0; idle(5);
    check("t6_nsend", q_tx.size(), 32'd0);
    clear_logs(); put_seq(64'hA5023412785616, 7); idle(4);
    check("t6_samp0", q_samp[0], 32'h1234);
    check("t6_samp1", q_samp[1], 32'h5678);
    check("t6_frame", q_fr[0], 32'h4);
    check("t6_reply", q_tx[0], 32'h06);

    // randomized frames against the model
    rnd_tx = 1'b1;
    for (int f = 0; f < 150; f++) begin
      fb.delete();
      fr = $urandom_range(0, 19);
      if (fr == 0) repeat ($urandom_range(1, 3)) fb.push_back(8'($urandom));
      fb.push_back(8'hA5);
      if (fr == 1)      fl = 0;
      else if (fr == 2) fl = $urandom_range(TB_MAX + 1, 255);
      else              fl = $urandom_range(1, TB_MAX);
      fb.push_back(8'(fl));
      fs = fl;
      if (fl >= 1 && fl <= TB_MAX) begin
        for (int i = 0; i < 2 * fl; i++) begin
          pb = 8'($urandom); fb.push_back(pb); fs += int'(pb);
        end
        fb.push_back((fr == 3 || fr == 4) ? 8'(fs + 1) : 8'(fs));
      end
      for (int i = 0; i < fb.size(); i++) begin
        gap = (fr == 5 && i == fb.size() / 2) ? TB_T - 1 + $urandom_range(0, 2) : $urandom_range(0, 2);
        if (i > 0) idle(gap);
        put(fb[i]);
      end
    end
    rnd_tx = 1'b0; tx_ready = 1'b1;
    idle(TB_T + 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-stream consumer and responder sitting directly on the UART byte interface of the series-preprocessing front end. Consumes received bytes (`data_out`/`data_valid`), locates and validates framed sample packets from the PC, streams 16-bit samples to the preprocessing pipeline, and answers each frame with a one-byte ACK/NAK through the transmit side (`send`/`data_in`/`tx_ready`).

## Interface
- `MAX_SAMPLES`, 64: largest legal LEN field (1..255).
- `TIMEOUT_CYCLES`, 50000: inter-byte idle limit inside a frame (1 ms at 50 MHz).
- `clk` in 1: single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `rx_byte` in 8: received byte, connects to UART `data_out`.
- `rx_valid` in 1: one-cycle pulse per received byte, connects to `data_valid`.
- `tx_ready` in 1: transmitter idle.
- `send` out 1: one-cycle pulse to transmit `tx_byte`.
- `tx_byte` out 8: reply byte, stable while `send`=1.
- `sample_data` out 16: assembled little-endian sample.
- `sample_valid` out 1: one-cycle pulse; no backpressure.
- `frame_done` out 1: one-cycle pulse at frame end (good or bad).
- `frame_ok` out 1: qualifies `frame_done`; 1 = valid frame.
- `err_code` out 2: 0 none, 1 bad LEN, 2 bad checksum, 3 timeout; held until next `frame_done`.
- `reply_overrun` out 1: one-cycle pulse when a reply replaces an unsent one.

## Operation
- Frame: SOF 0xA5, LEN, 2×LEN payload bytes (sample low byte first), CHK.
- CHK = (LEN + all payload bytes) mod 256.
- FSM states: IDLE, LEN, PAY_LO, PAY_HI, CHK.
  - IDLE: bytes ≠ 0xA5 discarded; 0xA5 → LEN.
  - LEN: 0 or > MAX_SAMPLES → frame end, err 1, → IDLE; else load sample counter, seed checksum, → PAY_LO.
  - PAY_LO → PAY_HI; PAY_HI emits sample, decrements counter; counter 0 → CHK else PAY_LO.
  - CHK: compare → frame end, err 0 or 2, → IDLE.
- 0xA5 inside a frame is payload, never resync.
- Samples stream before checksum is known; downstream discards on `frame_ok`=0.
- Timeout: counter runs in every state except IDLE, cleared by each `rx_valid`; reaching TIMEOUT_CYCLES → frame end, err 3, → IDLE.
- Frame end loads reply slot: ACK 0x06 if ok, NAK 0x15 otherwise. Slot already pending → overwritten, `reply_overrun` pulses.
- Reply issued when slot pending and `tx_ready`=1; slot clears on issue.

## Timing
- Reset values: `send`, `sample_valid`, `frame_done`, `frame_ok`, `reply_overrun` = 0; `tx_byte`, `sample_data` = 0x00/0x0000; `err_code` = 0; FSM IDLE; slot empty; counters 0.
- All outputs registered.
- `sample_valid` high cycle after the PAY_HI byte's `rx_valid`.
- `frame_done` high cycle after the CHK/bad-LEN byte's `rx_valid`, or cycle after timeout count reached.
- Slot loads on same edge that raises `frame_done`; `send` rises earliest the following cycle (cycle N+1 when at N slot pending, `tx_ready`=1, `send`=0). `send` never high two consecutive cycles.
- `rx_valid` in the cycle timeout would expire: byte wins, counter clears.
- Frame end and `send` issue same cycle: old reply sent, new reply loads, no overrun.
- Reset mid-frame or with reply pending: frame and reply dropped, no `send`.

## Structure
- Package `uart_frame_pkg`: SOF/ACK/NAK constants, FSM state enum, `err_code` enum.
- Sub-module `uart_byte_timeout`: clear/enable counter with `expired` pulse, width $clog2(TIMEOUT_CYCLES+1).

## Test plan
- A5 02 34 12 78 56 16 → samples 0x1234, 0x5678; `frame_ok`=1, err 0; `send` with 0x06.
- Same with CHK 0x17 → both samples emitted; `frame_ok`=0, err 2; NAK 0x15.
- 00 FF A5 01 CD AB 79 → leading bytes ignored; sample 0xABCD; ACK. Then A5 00 → err 1, NAK, next A5 parsed normally.
- A5 01 34 then idle TIMEOUT_CYCLES → err 3, NAK, FSM IDLE; byte at exact expiry cycle instead → no timeout.
- `tx_ready` held low 1000 cycles after good frame → no `send`; single `send` 0x06 cycle after `tx_ready` rises; second frame completing while still blocked → `reply_overrun`, only newer reply sent.
- `reset` asserted after A5 02 34 → no outputs, no `send`; following full good frame decodes correctly.
